// File: rtl/spi_frame_rx.sv
// SPI receive front end: synchronises the pad CSb/SCLK/MOSI, deserialises MSB-first frames
// and hands each completed frame downstream through a one-entry valid/ready holding register.
module spi_frame_rx #(
  parameter int FRAME_BITS  = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic                  csb_i,
  input  logic                  sclk_i,
  input  logic                  mosi_i,
  input  logic                  clr_fault_i,
  output logic [FRAME_BITS-1:0] frame_o,
  output logic                  frame_valid_o,
  input  logic                  frame_ready_i,
  output logic                  busy_o,
  output logic                  short_frame_o,
  output logic                  long_frame_o,
  output logic                  overrun_o,
  output logic [15:0]           frame_count_o
);

  localparam int CW = $clog2(FRAME_BITS + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, OVER} state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [SYNC_STAGES-1:0] r_csbSync;
  logic [SYNC_STAGES-1:0] r_sclkSync;
  logic [SYNC_STAGES-1:0] r_mosiSync;
  logic                  r_sclkD;
  logic                  r_armed;
  logic [FRAME_BITS-2:0] r_shift;
  logic [CW-1:0]         r_count;
  logic                  r_longHit;
  logic [FRAME_BITS-1:0] r_frame;
  logic                  r_valid;
  logic [15:0]           r_frameCount;
  logic                  r_short;
  logic                  r_long;
  logic                  r_overrun;

  logic w_csbS;
  logic w_sclkS;
  logic w_mosiS;
  logic w_rise;
  logic w_start;
  logic w_shiftEn;
  logic w_complete;
  logic w_setShort;
  logic w_setLong;
  logic w_xfer;
  logic w_load;
  logic w_drop;

  // CSb resets to "low" so a window already open at reset release never arms the block.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_csbSync  <= '0;
      r_sclkSync <= '0;
      r_mosiSync <= '0;
    end else begin
      r_csbSync  <= {r_csbSync[SYNC_STAGES-2:0], csb_i};
      r_sclkSync <= {r_sclkSync[SYNC_STAGES-2:0], sclk_i};
      r_mosiSync <= {r_mosiSync[SYNC_STAGES-2:0], mosi_i};
    end
  end

  assign w_csbS  = r_csbSync[SYNC_STAGES-1];
  assign w_sclkS = r_sclkSync[SYNC_STAGES-1];
  assign w_mosiS = r_mosiSync[SYNC_STAGES-1];
  assign w_rise  = w_sclkS & ~r_sclkD;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= IDLE;
      r_sclkD <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_sclkD <= w_sclkS;
      if (w_csbS) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_start     = 1'b0;
    w_shiftEn   = 1'b0;
    w_complete  = 1'b0;
    w_setShort  = 1'b0;
    w_setLong   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_csbS && r_armed) begin
          w_nextState = SHIFT;
          w_start     = 1'b1;
        end
      end
      SHIFT: begin
        if (w_csbS) begin
          w_nextState = IDLE;
          w_setShort  = (r_count != '0);
        end else if (w_rise) begin
          w_shiftEn = 1'b1;
          if (r_count == LAST_BIT) begin
            w_complete  = 1'b1;
            w_nextState = OVER;
          end
        end
      end
      OVER: begin
        if (w_csbS) begin
          w_nextState = IDLE;
        end else if (w_rise && !r_longHit) begin
          w_setLong = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // A completion may reuse the slot on the same edge the downstream side drains it.
  assign w_xfer = r_valid & frame_ready_i;
  assign w_load = w_complete & (~r_valid | w_xfer);
  assign w_drop = w_complete & r_valid & ~w_xfer;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_shift      <= '0;
      r_count      <= '0;
      r_longHit    <= 1'b0;
      r_frame      <= '0;
      r_valid      <= 1'b0;
      r_frameCount <= '0;
      r_short      <= 1'b0;
      r_long       <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_start) begin
        r_shift   <= '0;
        r_count   <= '0;
        r_longHit <= 1'b0;
      end else if (w_shiftEn) begin
        r_shift <= {r_shift[FRAME_BITS-3:0], w_mosiS};
        r_count <= r_count + 1'b1;
      end
      if (w_setLong) begin
        r_longHit <= 1'b1;
      end

      if (w_load) begin
        r_frame      <= {r_shift, w_mosiS};
        r_valid      <= 1'b1;
        r_frameCount <= r_frameCount + 16'd1;
      end else if (w_xfer) begin
        r_valid <= 1'b0;
      end

      // Sticky flags: a set on the same edge as a clear wins.
      if (w_setShort) begin
        r_short <= 1'b1;
      end else if (clr_fault_i) begin
        r_short <= 1'b0;
      end
      if (w_setLong) begin
        r_long <= 1'b1;
      end else if (clr_fault_i) begin
        r_long <= 1'b0;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
      end else if (clr_fault_i) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign frame_o       = r_frame;
  assign frame_valid_o = r_valid;
  assign busy_o        = r_armed & ~w_csbS;
  assign short_frame_o = r_short;
  assign long_frame_o  = r_long;
  assign overrun_o     = r_overrun;
  assign frame_count_o = r_frameCount;

endmodule

// File: tb/tb_spi_frame_rx.sv
// Directed bench for spi_frame_rx: drives mode-0 SPI frames on the pads and checks
// the held frame, handshake, frame counter and sticky fault flags.
module tb_spi_frame_rx;

  localparam int PHASE = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        csb;
  logic        sclk;
  logic        mosi;
  logic        clrFault;
  logic        frameReady;
  logic [23:0] frame;
  logic        frameValid;
  logic        busy;
  logic        shortFrame;
  logic        longFrame;
  logic        overrun;
  logic [15:0] frameCount;

  int checkCount  = 0;
  int passCount   = 0;
  int validCycles = 0;
  int validBase;
  logic [31:0] valB;

  always #5 clk = ~clk;

  spi_frame_rx #(.FRAME_BITS(24), .SYNC_STAGES(2)) dut (
    .wb_clk_i      (clk),
    .wb_rst_i      (rst),
    .csb_i         (csb),
    .sclk_i        (sclk),
    .mosi_i        (mosi),
    .clr_fault_i   (clrFault),
    .frame_o       (frame),
    .frame_valid_o (frameValid),
    .frame_ready_i (frameReady),
    .busy_o        (busy),
    .short_frame_o (shortFrame),
    .long_frame_o  (longFrame),
    .overrun_o     (overrun),
    .frame_count_o (frameCount)
  );

  // Counts cycles with the holding register valid, sampled between active edges.
  always @(negedge clk) begin
    if (frameValid === 1'b1) begin
      validCycles++;
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic c, input logic s, input logic m, input int cycles);
    csb  = c;
    sclk = s;
    mosi = m;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic startFrame();
    applyStimulus(1'b0, 1'b0, 1'b0, PHASE);
  endtask

  task automatic shiftBits(input logic [31:0] value, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      applyStimulus(1'b0, 1'b0, value[i], PHASE);
      applyStimulus(1'b0, 1'b1, value[i], PHASE);
    end
  endtask

  task automatic endFrame();
    applyStimulus(1'b0, 1'b0, mosi, PHASE);
    applyStimulus(1'b1, 1'b0, mosi, 2 * PHASE);
  endtask

  task automatic sendFrame(input logic [31:0] value, input int n);
    startFrame();
    shiftBits(value, n);
    endFrame();
  endtask

  task automatic pulseClear();
    clrFault = 1'b1;
    @(posedge clk);
    #1;
    clrFault = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    csb        = 1'b1;
    sclk       = 1'b0;
    mosi       = 1'b0;
    clrFault   = 1'b0;
    frameReady = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_frame", 32'(frame), 32'h0);
    checkOutput("rst_valid", 32'(frameValid), 32'h0);
    checkOutput("rst_busy", 32'(busy), 32'h0);
    checkOutput("rst_flags", {29'h0, shortFrame, longFrame, overrun}, 32'h0);
    checkOutput("rst_count", 32'(frameCount), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 6);

    $display("[TB] single frame with ready high");
    validBase = validCycles;
    startFrame();
    @(negedge clk);
    checkOutput("busy_in_frame", 32'(busy), 32'h1);
    shiftBits(32'hA51234, 24);
    endFrame();
    @(negedge clk);
    checkOutput("f1_frame", 32'(frame), 32'hA51234);
    checkOutput("f1_valid_cycles", 32'(validCycles - validBase), 32'h1);
    checkOutput("f1_count", 32'(frameCount), 32'h1);
    checkOutput("f1_busy_after", 32'(busy), 32'h0);

    $display("[TB] overrun with ready low");
    frameReady = 1'b0;
    sendFrame(32'h800001, 24);
    @(negedge clk);
    checkOutput("ov_first_frame", 32'(frame), 32'h800001);
    checkOutput("ov_first_valid", 32'(frameValid), 32'h1);
    sendFrame(32'h7FFFFE, 24);
    @(negedge clk);
    checkOutput("ov_frame_kept", 32'(frame), 32'h800001);
    checkOutput("ov_flag", 32'(overrun), 32'h1);
    checkOutput("ov_count", 32'(frameCount), 32'h2);
    pulseClear();
    @(negedge clk);
    checkOutput("ov_cleared", 32'(overrun), 32'h0);
    frameReady = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("ov_drained", 32'(frameValid), 32'h0);

    $display("[TB] short frame then good frame");
    validBase = validCycles;
    sendFrame(32'h2AB, 10);
    @(negedge clk);
    checkOutput("sh_flag", 32'(shortFrame), 32'h1);
    checkOutput("sh_no_valid", 32'(validCycles - validBase), 32'h0);
    checkOutput("sh_count", 32'(frameCount), 32'h2);
    sendFrame(32'h000F0F, 24);
    @(negedge clk);
    checkOutput("sh_next_frame", 32'(frame), 32'h000F0F);
    checkOutput("sh_next_count", 32'(frameCount), 32'h3);
    checkOutput("sh_still_sticky", 32'(shortFrame), 32'h1);
    pulseClear();

    $display("[TB] long frame of 26 bits");
    sendFrame(32'h48D15A, 26);
    @(negedge clk);
    checkOutput("lg_frame", 32'(frame), 32'h123456);
    checkOutput("lg_flag", 32'(longFrame), 32'h1);
    checkOutput("lg_count", 32'(frameCount), 32'h4);
    checkOutput("lg_no_short", 32'(shortFrame), 32'h0);
    pulseClear();
    @(negedge clk);
    checkOutput("lg_cleared", 32'(longFrame), 32'h0);

    $display("[TB] reset in the middle of a frame");
    startFrame();
    shiftBits(32'h5A5, 12);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("mr_frame", 32'(frame), 32'h0);
    checkOutput("mr_count", 32'(frameCount), 32'h0);
    checkOutput("mr_valid", 32'(frameValid), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    validBase = validCycles;
    shiftBits(32'h0F0, 12);
    @(negedge clk);
    checkOutput("mr_not_busy", 32'(busy), 32'h0);
    endFrame();
    @(negedge clk);
    checkOutput("mr_ignored", 32'(validCycles - validBase), 32'h0);
    checkOutput("mr_frame_zero", 32'(frame), 32'h0);
    sendFrame(32'hC0FFEE, 24);
    @(negedge clk);
    checkOutput("mr_new_frame", 32'(frame), 32'hC0FFEE);
    checkOutput("mr_new_count", 32'(frameCount), 32'h1);
    checkOutput("mr_flags", {29'h0, shortFrame, longFrame, overrun}, 32'h0);

    $display("[TB] frame counter wrap");
    force dut.r_frameCount = 16'hFFFF;
    @(posedge clk);
    #1;
    release dut.r_frameCount;
    sendFrame(32'h135799, 24);
    @(negedge clk);
    checkOutput("wr_count", 32'(frameCount), 32'h0);
    checkOutput("wr_frame", 32'(frame), 32'h135799);

    $display("[TB] completion on the same edge as a transfer");
    frameReady = 1'b0;
    sendFrame(32'h111111, 24);
    valB = 32'h2468AC;
    startFrame();
    shiftBits(valB >> 1, 23);
    applyStimulus(1'b0, 1'b0, valB[0], PHASE);
    sclk = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    frameReady = 1'b1;
    @(posedge clk);
    #1;
    frameReady = 1'b0;
    applyStimulus(1'b0, 1'b1, valB[0], PHASE);
    endFrame();
    @(negedge clk);
    checkOutput("se_frame", 32'(frame), 32'h2468AC);
    checkOutput("se_valid", 32'(frameValid), 32'h1);
    checkOutput("se_no_overrun", 32'(overrun), 32'h0);
    checkOutput("se_count", 32'(frameCount), 32'h2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
